// File: rtl/fetch_stage_ctrl_if.sv
// rtl/fetch_stage_ctrl_if.sv - instruction memory request/ready interface for the fetch stage
interface fetch_stage_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/fetch_stage_ctrl.sv
// rtl/fetch_stage_ctrl.sv - IF stage + IF/ID register with hold buffer and branch redirect
// Optional feature: BRANCH_DELAY_SLOT_EN keeps the F instruction at a redirect (delay slot).
module fetch_stage_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       StallF,
    input  logic                       StallD,
    input  logic                       PCSrcD,
    input  logic [31:0]                PCBranchD,
    fetch_stage_ctrl_if.master         imem,
    output logic [31:0]                InstrD,
    output logic [31:0]                PCPlus4D,
    output logic                       ValidD,
    output logic                       FetchStallReq
);
    typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

    state_t      state, state_nx;
    logic [31:0] pcf, pcf_nx;
    logic        redir_pend, redir_pend_nx;
    logic [31:0] redir_tgt, redir_tgt_nx;
    logic [31:0] hold_instr, hold_pc4;
    logic        hold_load;

    logic        done, avail, redir_now, redir_any, consume, squash;
    logic [31:0] tgt, pc_plus4, f_instr, f_pc4;

    always_comb begin
        done      = (state == FETCH) && imem.imem_ready;
        avail     = done || (state == HOLD);
        redir_now = PCSrcD && !StallD;
        redir_any = redir_now || redir_pend;
        tgt       = redir_now ? PCBranchD : redir_tgt;
        pc_plus4  = pcf + 32'd4;
        f_instr   = (state == HOLD) ? hold_instr : imem.imem_rdata;
        f_pc4     = (state == HOLD) ? hold_pc4 : pc_plus4;
        // A redirect forces consumption even if StallF is (illegally) high without StallD.
        consume   = avail && (!StallF || redir_now);
`ifdef BRANCH_DELAY_SLOT_EN
        squash    = 1'b0;
`else
        squash    = redir_any;
`endif

        state_nx      = state;
        pcf_nx        = pcf;
        redir_pend_nx = redir_pend;
        redir_tgt_nx  = redir_tgt;
        hold_load     = 1'b0;

        case (state)
            BOOT: state_nx = FETCH;
            FETCH: begin
                if (consume) begin
                    pcf_nx        = redir_any ? tgt : pc_plus4;
                    redir_pend_nx = 1'b0;
                end else if (done) begin
                    state_nx  = HOLD;
                    hold_load = 1'b1;
                end else if (redir_now) begin
                    redir_pend_nx = 1'b1;
                    redir_tgt_nx  = PCBranchD;
                end
            end
            HOLD: begin
                if (consume) begin
                    state_nx      = FETCH;
                    pcf_nx        = redir_any ? tgt : pc_plus4;
                    redir_pend_nx = 1'b0;
                end
            end
            default: state_nx = BOOT;
        endcase

        imem.imem_req  = (state == FETCH);
        imem.imem_addr = pcf;
        FetchStallReq  = (state == FETCH) && !imem.imem_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= BOOT;
            pcf        <= RESET_PC;
            redir_pend <= 1'b0;
            redir_tgt  <= 32'h0;
            hold_instr <= 32'h0;
            hold_pc4   <= 32'h0;
            InstrD     <= NOP_INSTR;
            PCPlus4D   <= 32'h0;
            ValidD     <= 1'b0;
        end else begin
            state      <= state_nx;
            pcf        <= pcf_nx;
            redir_pend <= redir_pend_nx;
            redir_tgt  <= redir_tgt_nx;
            if (hold_load) begin
                hold_instr <= imem.imem_rdata;
                hold_pc4   <= pc_plus4;
            end
            if (!StallD) begin
                if (consume && !squash) begin
                    InstrD   <= f_instr;
                    PCPlus4D <= f_pc4;
                    ValidD   <= 1'b1;
                end else begin
                    InstrD <= NOP_INSTR;
                    ValidD <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// tb/tb_fetch_stage_ctrl.sv - directed self-checking bench for fetch_stage_ctrl
module tb_fetch_stage_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, StallF, StallD, PCSrcD;
    logic [31:0] PCBranchD;
    logic [31:0] InstrD, PCPlus4D;
    logic        ValidD, FetchStallReq;
    logic        ovr;
    logic [31:0] ovr_data;
    int          n_cmp = 0;
    int          n_err = 0;

    fetch_stage_ctrl_if bus ();

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign bus.imem_rdata = ovr ? ovr_data : mem(bus.imem_addr);

    fetch_stage_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .StallF       (StallF),
        .StallD       (StallD),
        .PCSrcD       (PCSrcD),
        .PCBranchD    (PCBranchD),
        .imem         (bus.master),
        .InstrD       (InstrD),
        .PCPlus4D     (PCPlus4D),
        .ValidD       (ValidD),
        .FetchStallReq(FetchStallReq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0;
        PCBranchD = 32'h0; ovr = 1'b0; ovr_data = 32'h0;
        bus.imem_ready = 1'b1;
        step(); step();
        chk("rst_req",   {31'h0, bus.imem_req}, 32'h0);
        chk("rst_fsr",   {31'h0, FetchStallReq}, 32'h0);
        chk("rst_valid", {31'h0, ValidD}, 32'h0);
        chk("rst_instr", InstrD, 32'h0);
        chk("rst_pc4",   PCPlus4D, 32'h0);
        chk("rst_addr",  bus.imem_addr, 32'h0);

        // Zero-wait streaming
        rst_n = 1'b1;
        step();
        chk("boot_req",  {31'h0, bus.imem_req}, 32'h1);
        chk("boot_addr", bus.imem_addr, 32'h0);
        chk("boot_valid", {31'h0, ValidD}, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("seq_addr",  bus.imem_addr, 32'(4 * i));
            chk("seq_instr", InstrD, mem(32'(4 * (i - 1))));
            chk("seq_pc4",   PCPlus4D, 32'(4 * i));
            chk("seq_valid", {31'h0, ValidD}, 32'h1);
        end

        // Wait states at 0x10
        for (int i = 0; i < 3; i++) begin
            bus.imem_ready = 1'b0;
            #1;
            chk("ws_fsr",  {31'h0, FetchStallReq}, 32'h1);
            step();
            chk("ws_addr",  bus.imem_addr, 32'h10);
            chk("ws_valid", {31'h0, ValidD}, 32'h0);
            chk("ws_instr", InstrD, 32'h0);
        end
        bus.imem_ready = 1'b1;
        #1;
        chk("ws_fsr_clr", {31'h0, FetchStallReq}, 32'h0);
        step();
        chk("ws_done_instr", InstrD, mem(32'h10));
        chk("ws_done_valid", {31'h0, ValidD}, 32'h1);
        chk("ws_done_addr",  bus.imem_addr, 32'h14);

        // Stall while 0x2108_0001 returns from 0x14
        ovr = 1'b1; ovr_data = 32'h2108_0001; StallF = 1'b1; StallD = 1'b1;
        step();
        ovr = 1'b0;
        chk("hold_req",   {31'h0, bus.imem_req}, 32'h0);
        chk("hold_fsr",   {31'h0, FetchStallReq}, 32'h0);
        chk("hold_instr", InstrD, mem(32'h10));
        step();
        chk("hold2_req",  {31'h0, bus.imem_req}, 32'h0);
        StallF = 1'b0; StallD = 1'b0;
        step();
        chk("rel_instr", InstrD, 32'h2108_0001);
        chk("rel_pc4",   PCPlus4D, 32'h18);
        chk("rel_valid", {31'h0, ValidD}, 32'h1);
        chk("rel_addr",  bus.imem_addr, 32'h18);

        // Redirect with ready=1 at 0x18
        PCSrcD = 1'b1; PCBranchD = 32'h100;
        step();
        PCSrcD = 1'b0;
        chk("br_addr", bus.imem_addr, 32'h100);
`ifdef BRANCH_DELAY_SLOT_EN
        chk("br_valid", {31'h0, ValidD}, 32'h1);
        chk("br_instr", InstrD, mem(32'h18));
        chk("br_pc4",   PCPlus4D, 32'h1C);
`else
        chk("br_valid", {31'h0, ValidD}, 32'h0);
        chk("br_instr", InstrD, 32'h0);
        chk("br_pc4",   PCPlus4D, 32'h18);
`endif
        step();
        chk("br_tgt_instr", InstrD, mem(32'h100));
        chk("br_tgt_pc4",   PCPlus4D, 32'h104);
        chk("br_next_addr", bus.imem_addr, 32'h104);

        // Redirect during an outstanding fetch at 0x40
        PCSrcD = 1'b1; PCBranchD = 32'h40;
        step();
        chk("to40_addr", bus.imem_addr, 32'h40);
        PCBranchD = 32'h200; bus.imem_ready = 1'b0;
        step();
        PCSrcD = 1'b0;
        chk("pend_addr1", bus.imem_addr, 32'h40);
        chk("pend_valid", {31'h0, ValidD}, 32'h0);
        step();
        chk("pend_addr2", bus.imem_addr, 32'h40);
        bus.imem_ready = 1'b1;
        step();
        chk("pend_redir_addr", bus.imem_addr, 32'h200);
`ifdef BRANCH_DELAY_SLOT_EN
        chk("pend_kept_instr", InstrD, mem(32'h40));
        chk("pend_kept_valid", {31'h0, ValidD}, 32'h1);
`else
        chk("pend_disc_instr", InstrD, 32'h0);
        chk("pend_disc_valid", {31'h0, ValidD}, 32'h0);
`endif
        step();
        chk("pend_tgt_instr", InstrD, mem(32'h200));
        chk("pend_tgt_addr",  bus.imem_addr, 32'h204);

        // Reset during an outstanding fetch; late ready in BOOT is ignored
        bus.imem_ready = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        chk("mrst_req",   {31'h0, bus.imem_req}, 32'h0);
        chk("mrst_addr",  bus.imem_addr, 32'h0);
        chk("mrst_valid", {31'h0, ValidD}, 32'h0);
        chk("mrst_fsr",   {31'h0, FetchStallReq}, 32'h0);
        rst_n = 1'b1; bus.imem_ready = 1'b1;
        step();
        chk("late_addr",  bus.imem_addr, 32'h0);
        chk("late_valid", {31'h0, ValidD}, 32'h0);

        // PC wrap at 0xFFFF_FFFC
        PCSrcD = 1'b1; PCBranchD = 32'hFFFF_FFFC;
        step();
        PCSrcD = 1'b0;
        chk("wrap_top", bus.imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr",  bus.imem_addr, 32'h0);
        chk("wrap_instr", InstrD, mem(32'hFFFF_FFFC));
        chk("wrap_pc4",   PCPlus4D, 32'h0);
        chk("wrap_valid", {31'h0, ValidD}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
